// File: rtl/ask_mod_pkg.sv
// Shared types and helpers for the ASK modulator: serializer states, scramble index math,
// and the default LFSR polynomial and seed.
package ask_mod_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'h0001;

    // Source bit index feeding scrambled output bit i.
    function automatic int perm_idx(input int i, input int stride, input int word_w);
        return (i * stride) % word_w;
    endfunction

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

endpackage

// File: rtl/ask_modulator_p_lfsr_gen.sv
// Galois LFSR bit source; steps only when adv=1, load takes priority and a zero seed becomes 1.
// outbit is the current LFSR[0], i.e. the bit consumed by the step that adv enables.
import ask_mod_pkg::*;

module lfsr_gen #(
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  TAPS   = DEF_TAPS,
    parameter logic [LFSR_W-1:0]  SEED   = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              adv,
    output logic              outbit
);

    localparam logic [LFSR_W-1:0] ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed_in == '0) ? ONE : seed_in;
        end else if (adv) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign outbit = lfsr_q[0];

endmodule

// File: rtl/ask_modulator_p.sv
// ASK transmit modulator: LFSR bits packed into words, optionally stride-scrambled, sent MSB-first.
// Each serial bit is held BIT_CYC clocks; generation stalls while the one-word holding buffer is full.
import ask_mod_pkg::*;

module ask_modulator_p #(
    parameter int                 WORD_W  = 12,
    parameter int                 LFSR_W  = 16,
    parameter logic [LFSR_W-1:0]  TAPS    = DEF_TAPS,
    parameter logic [LFSR_W-1:0]  SEED    = DEF_SEED,
    parameter int                 STRIDE  = 5,
    parameter int                 BIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              enable,
    input  logic              scramble_en,
    output logic              ser_out,
    output logic              new_word,
    output logic [WORD_W-1:0] word_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int BC_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    if (WORD_W < 2 || WORD_W > 32) begin : g_bad_width
        $error("WORD_W must be in 2..32");
    end
    if (gcd(STRIDE, WORD_W) != 1) begin : g_bad_stride
        $error("STRIDE must be coprime with WORD_W");
    end
    if (BIT_CYC < 1) begin : g_bad_bitcyc
        $error("BIT_CYC must be at least 1");
    end

    logic [WORD_W-1:0] asm_q, asm_d, asm_shift;
    logic [CNT_W-1:0]  asm_cnt_q, asm_cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              new_word_q, new_word_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]   cyc_cnt_q, cyc_cnt_d;

    logic              stall;
    logic              adv;
    logic              outbit;
    logic              pop;
    logic [WORD_W-1:0] scr_w;
    logic [WORD_W-1:0] word_s;

    assign stall = buf_full_q && (asm_cnt_q == CNT_W'(WORD_W - 1));
    assign adv   = enable && !stall && !load;

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .seed_in (seed_in),
        .adv     (adv),
        .outbit  (outbit)
    );

    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_perm
        assign scr_w[gi] = buf_q[perm_idx(gi, STRIDE, WORD_W)];
    end

    assign word_s    = scramble_en ? scr_w : buf_q;
    assign asm_shift = {asm_q[WORD_W-2:0], outbit};

    // Serializer: a word is pulled from the buffer whenever one is ready and enable is high.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        new_word_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_full_q && enable) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cyc_cnt_q == BC_W'(BIT_CYC - 1)) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                        if (buf_full_q && enable) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sreg_d    = sreg_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            sreg_d     = word_s;
            word_d     = word_s;
            bit_cnt_d  = '0;
            cyc_cnt_d  = '0;
            new_word_d = 1'b1;
        end
    end

    // A reseed discards the partial word so the next word starts cleanly at the new seed.
    always_comb begin
        asm_d      = asm_q;
        asm_cnt_d  = asm_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q && !pop;
        if (load) begin
            asm_cnt_d = '0;
        end else if (adv) begin
            asm_d = asm_shift;
            if (asm_cnt_q == CNT_W'(WORD_W - 1)) begin
                buf_d      = asm_shift;
                buf_full_d = 1'b1;
                asm_cnt_d  = '0;
            end else begin
                asm_cnt_d = asm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            asm_cnt_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            state_q    <= IDLE;
            sreg_q     <= '0;
            word_q     <= '0;
            new_word_q <= 1'b0;
            bit_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            asm_q      <= asm_d;
            asm_cnt_q  <= asm_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            word_q     <= word_d;
            new_word_q <= new_word_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign ser_out  = (state_q == SHIFT) && sreg_q[WORD_W-1];
    assign new_word = new_word_q;
    assign word_out = word_q;

endmodule
